// File: rtl/blastit_uart_pkg.sv
// Shared constants, FSM state types and derived-timing helpers for the OBD2 UART link.
package blastit_uart_pkg;

  localparam int unsigned OVS = 16;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Rounded divider for the 16x oversampling tick
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud * 8) / (baud * 16);
  endfunction

  function automatic int unsigned calc_timeout(input int unsigned clk_hz, input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/obd_uart_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO succeeds only alongside a pop.
module obd_uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, wr_en, rd_en;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/obd_uart_link.sv
// Buffered 8N1 UART link to the ELM327-style adapter with prompt detection and response watchdog.
module obd_uart_link
  import blastit_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned BAUD        = 38400,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [7:0]  PROMPT_CHAR = 8'h3E,
  parameter int unsigned TIMEOUT_MS  = 500
) (
  input  logic                          clock_50_clk,
  input  logic                          reset_reset_n,
  input  logic                          uart_rx,
  output logic                          uart_tx,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          prompt_seen,
  output logic                          rx_frame_err,
  output logic                          rx_overflow,
  output logic                          resp_timeout,
  input  logic                          clear_err
);

  localparam int unsigned DIV         = calc_div(CLK_HZ, BAUD);
  localparam int unsigned TIMEOUT_CYC = calc_timeout(CLK_HZ, TIMEOUT_MS);
  localparam int unsigned DW          = $clog2(DIV + 1);
  localparam int unsigned TW          = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned LW          = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW          = $clog2(DATA_BITS + 1);

  logic [DW-1:0] tick_cnt;
  logic          tick;

  logic [1:0]           rx_sync;
  logic                 rx_in;
  rx_state_t            rx_state, rx_state_n;
  logic [3:0]           rx_cnt, rx_cnt_n;
  logic [BW-1:0]        rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                 rx_push, ferr_set, ovf_set, rx_empty, rx_full;

  tx_state_t            tx_state, tx_state_n;
  logic [3:0]           tx_cnt, tx_cnt_n;
  logic [BW-1:0]        tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n, tx_head;
  logic [LW-1:0]        tx_level;
  logic                 tx_pop, tx_push, tx_empty, wd_arm;

  logic [TW-1:0] wd_cnt;
  logic          wd_armed, wd_fire;

  assign tick = (tick_cnt == DW'(DIV - 1));
  assign rx_in = rx_sync[1];

  always_ff @(posedge clock_50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tick_cnt <= '0;
      rx_sync  <= '1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + DW'(1);
      rx_sync  <= {rx_sync[0], uart_rx};
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state)
      RX_IDLE: if (!rx_in) begin
        rx_state_n = RX_START;
        rx_cnt_n   = '0;
      end
      RX_START: if (tick) begin
        if (rx_cnt == 4'(OVS / 2 - 1)) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_in ? RX_IDLE : RX_DATA;
        end else rx_cnt_n = rx_cnt + 4'd1;
      end
      RX_DATA: if (tick) begin
        if (rx_cnt == 4'(OVS - 1)) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_in, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == BW'(DATA_BITS - 1)) rx_state_n = RX_STOP;
          else rx_bit_n = rx_bit + BW'(1);
        end else rx_cnt_n = rx_cnt + 4'd1;
      end
      RX_STOP: if (tick) begin
        if (rx_cnt == 4'(OVS - 1)) begin
          rx_cnt_n   = '0;
          rx_push    = rx_in;
          ferr_set   = !rx_in;
          rx_state_n = rx_in ? RX_IDLE : RX_BREAK;
        end else rx_cnt_n = rx_cnt + 4'd1;
      end
      RX_BREAK: if (rx_in) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // STOP reloads directly from the FIFO so consecutive frames carry no idle bit.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_pop     = 1'b0;
    wd_arm     = 1'b0;
    uart_tx    = 1'b1;
    case (tx_state)
      TX_IDLE: if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_shift_n = tx_head;
        tx_cnt_n   = '0;
        tx_state_n = TX_START;
      end
      TX_START: begin
        uart_tx = 1'b0;
        if (tick) begin
          if (tx_cnt == 4'(OVS - 1)) begin
            tx_cnt_n   = '0;
            tx_bit_n   = '0;
            tx_state_n = TX_DATA;
          end else tx_cnt_n = tx_cnt + 4'd1;
        end
      end
      TX_DATA: begin
        uart_tx = tx_shift[0];
        if (tick) begin
          if (tx_cnt == 4'(OVS - 1)) begin
            tx_cnt_n   = '0;
            tx_shift_n = tx_shift >> 1;
            if (tx_bit == BW'(DATA_BITS - 1)) tx_state_n = TX_STOP;
            else tx_bit_n = tx_bit + BW'(1);
          end else tx_cnt_n = tx_cnt + 4'd1;
        end
      end
      TX_STOP: if (tick) begin
        if (tx_cnt == 4'(OVS - 1)) begin
          tx_cnt_n = '0;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_head;
            tx_state_n = TX_START;
          end else begin
            wd_arm     = 1'b1;
            tx_state_n = TX_IDLE;
          end
        end else tx_cnt_n = tx_cnt + 4'd1;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  assign rx_full     = (rx_level == LW'(FIFO_DEPTH));
  assign rx_valid    = !rx_empty;
  assign prompt_seen = rx_push && (rx_shift == DATA_BITS'(PROMPT_CHAR));
  assign ovf_set     = rx_push && rx_full && !rx_ready;
  assign tx_ready    = (tx_level != LW'(FIFO_DEPTH));
  assign tx_push     = tx_valid && tx_ready;
  assign wd_fire     = wd_armed && (wd_cnt == TW'(TIMEOUT_CYC - 1)) &&
                       !prompt_seen && !tx_push && !wd_arm;

  always_ff @(posedge clock_50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wd_armed     <= 1'b0;
      wd_cnt       <= '0;
      rx_frame_err <= 1'b0;
      rx_overflow  <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      if (prompt_seen || tx_push) begin
        wd_armed <= 1'b0;
        wd_cnt   <= '0;
      end else if (wd_arm) begin
        wd_armed <= 1'b1;
        wd_cnt   <= '0;
      end else if (wd_fire) wd_armed <= 1'b0;
      else if (wd_armed) wd_cnt <= wd_cnt + TW'(1);

      if (ferr_set) rx_frame_err <= 1'b1;
      else if (clear_err) rx_frame_err <= 1'b0;
      if (ovf_set) rx_overflow <= 1'b1;
      else if (clear_err) rx_overflow <= 1'b0;
      if (wd_fire) resp_timeout <= 1'b1;
      else if (clear_err || prompt_seen) resp_timeout <= 1'b0;
    end
  end

  obd_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clock_50_clk),
    .rst_n (reset_reset_n),
    .push  (rx_push),
    .din   (rx_shift),
    .pop   (rx_ready),
    .dout  (rx_data),
    .empty (rx_empty),
    .level (rx_level)
  );

  obd_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clock_50_clk),
    .rst_n (reset_reset_n),
    .push  (tx_push),
    .din   (tx_data),
    .pop   (tx_pop),
    .dout  (tx_head),
    .empty (tx_empty),
    .level (tx_level)
  );

endmodule

// File: tb/tb_obd_uart_link.sv
// Directed bench for obd_uart_link at a scaled clock: DIV=2 (32 cycles/bit), watchdog 3200 cycles.
module tb_obd_uart_link;

  localparam int BIT = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_line = 1'b1;
  logic       loop = 1'b0;
  logic       uart_rx_w;
  logic       uart_tx;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [4:0] rx_level;
  logic       prompt_seen;
  logic       rx_frame_err;
  logic       rx_overflow;
  logic       resp_timeout;
  logic       clear_err = 1'b0;

  int total = 0;
  int bad = 0;
  int prompt_cnt = 0;
  int prompt_lvl = -1;
  int base;

  always #5 clk = ~clk;
  assign uart_rx_w = loop ? uart_tx : rx_line;

  obd_uart_link #(
    .CLK_HZ     (3_200_000),
    .BAUD       (100_000),
    .DATA_BITS  (8),
    .FIFO_DEPTH (16),
    .PROMPT_CHAR(8'h3E),
    .TIMEOUT_MS (1)
  ) dut (
    .clock_50_clk (clk),
    .reset_reset_n(rst_n),
    .uart_rx      (uart_rx_w),
    .uart_tx      (uart_tx),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_level     (rx_level),
    .prompt_seen  (prompt_seen),
    .rx_frame_err (rx_frame_err),
    .rx_overflow  (rx_overflow),
    .resp_timeout (resp_timeout),
    .clear_err    (clear_err)
  );

  always @(posedge clk) begin
    if (prompt_seen) begin
      prompt_cnt <= prompt_cnt + 1;
      prompt_lvl <= int'(rx_level);
    end
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_line = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx_line = stop;
    repeat (BIT) @(negedge clk);
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pop_check(input logic [7:0] exp, input string tag);
    chk(rx_valid, 1, {tag, "_valid"});
    chk(rx_data, exp, tag);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_tx(input logic v, input string tag);
    int n = 0;
    while (uart_tx !== v && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(uart_tx, v, tag);
  endtask

  task automatic wait_level(input int lvl, input int limit, input string tag);
    int n = 0;
    while (int'(rx_level) != lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(rx_level, lvl, tag);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk(uart_tx, 1, "rst_uart_tx");
    chk(tx_ready, 1, "rst_tx_ready");
    chk(rx_valid, 0, "rst_rx_valid");
    chk(rx_level, 0, "rst_rx_level");
    chk({rx_frame_err, rx_overflow, resp_timeout, prompt_seen}, 0, "rst_flags");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 6a: 4-tick glitch is rejected
    rx_line = 1'b0;
    repeat (8) @(negedge clk);
    rx_line = 1'b1;
    repeat (100) @(negedge clk);
    chk(rx_level, 0, "glitch_level");
    chk(rx_frame_err, 0, "glitch_ferr");

    // 2: "OK\r>" with one prompt pulse on the 3E push
    base = prompt_cnt;
    send_rx(8'h4F, 1'b1);
    send_rx(8'h4B, 1'b1);
    send_rx(8'h0D, 1'b1);
    chk(prompt_cnt - base, 0, "prompt_early");
    send_rx(8'h3E, 1'b1);
    chk(rx_level, 4, "ok_level");
    chk(prompt_cnt - base, 1, "prompt_count");
    chk(prompt_lvl, 3, "prompt_align");
    pop_check(8'h4F, "ok_b0");
    pop_check(8'h4B, "ok_b1");
    pop_check(8'h0D, "ok_b2");
    pop_check(8'h3E, "ok_b3");
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk(rx_level, 0, "pop_empty");

    // 3: framing error
    send_rx(8'h55, 1'b0);
    chk(rx_frame_err, 1, "ferr_set");
    chk(rx_level, 0, "ferr_level");
    pulse_clear();
    chk(rx_frame_err, 0, "ferr_clear");

    // 1: loopback of four back-to-back bytes
    loop = 1'b1;
    send_tx(8'h41);
    send_tx(8'h54);
    send_tx(8'h5A);
    send_tx(8'h0D);
    wait_level(4, 4 * 10 * BIT + 200, "loop_level");
    pop_check(8'h41, "loop_b0");
    pop_check(8'h54, "loop_b1");
    pop_check(8'h5A, "loop_b2");
    pop_check(8'h0D, "loop_b3");
    repeat (40) @(negedge clk);
    loop = 1'b0;
    chk(rx_level, 0, "loop_empty");

    // 5a: timeout exactly 3200 cycles after the stop bit ends (start->bit0 edge + 288)
    pulse_clear();
    send_tx(8'h41);
    wait_tx(1'b0, "wd_start");
    wait_tx(1'b1, "wd_bit0");
    repeat (9 * BIT + 3200 - 1) @(negedge clk);
    chk(resp_timeout, 0, "wd_before");
    @(negedge clk);
    chk(resp_timeout, 1, "wd_fire");
    pulse_clear();
    chk(resp_timeout, 0, "wd_clear");

    // 5b: prompt inside the window keeps resp_timeout low
    send_tx(8'h41);
    wait_tx(1'b0, "wd2_start");
    wait_tx(1'b1, "wd2_bit0");
    send_rx(8'h3E, 1'b1);
    repeat (9 * BIT + 3200 + 20 - 10 * BIT - 4) @(negedge clk);
    chk(resp_timeout, 0, "wd_prompt");
    pop_check(8'h3E, "wd_prompt_byte");

    // 4: overflow on the 17th byte
    for (int i = 1; i <= 17; i++) send_rx(8'(i), 1'b1);
    chk(rx_level, 16, "ovf_level");
    chk(rx_overflow, 1, "ovf_flag");
    for (int i = 1; i <= 15; i++) pop_check(8'(i), "ovf_pop");
    chk(rx_level, 1, "ovf_lost");
    chk(rx_data, 8'h10, "ovf_tail");

    // 6b: reset in the middle of TX data bit 1 (0xA5 bit1 = 0)
    send_tx(8'hA5);
    wait_tx(1'b0, "rst_tx_start");
    repeat (2 * BIT + 10) @(negedge clk);
    chk(uart_tx, 0, "mid_bit1");
    rst_n = 1'b0;
    #1;
    chk(uart_tx, 1, "abort_uart_tx");
    chk(tx_ready, 1, "abort_tx_ready");
    chk(rx_valid, 0, "abort_rx_valid");
    chk(rx_overflow, 0, "abort_ovf");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
